// File: rtl/rggen_rtl_pkg.sv
// rtl/rggen_rtl_pkg.sv - shared types for the register access sequencer
//
// Purpose: response status encodings and sequencer FSM state enum.
// Ports:   none (package).
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    STATUS_OKAY          = 2'b00,
    STATUS_DECODE_ERROR  = 2'b10,
    STATUS_TIMEOUT_ERROR = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    STATE_IDLE     = 2'b00,
    STATE_ACCESS   = 2'b01,
    STATE_RESPONSE = 2'b10
  } state_e;

endpackage

// File: rtl/rggen_or_reducer.sv
// rtl/rggen_or_reducer.sv - masked OR-reduction of a packed array of data words
//
// Purpose: result = OR over i of (mask[i] ? word[i] : 0).
// Ports:
//   mask   [COUNT-1:0]        per-word enable
//   data   [COUNT*WIDTH-1:0]  word i at [i*WIDTH +: WIDTH]
//   result [WIDTH-1:0]        combined word
module rggen_or_reducer #(
  parameter int WIDTH = 32,
  parameter int COUNT = 1
) (
  input  logic [COUNT-1:0]       mask,
  input  logic [COUNT*WIDTH-1:0] data,
  output logic [WIDTH-1:0]       result
);

  always_comb begin
    result = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (mask[i]) begin
        result = result | data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/rggen_register_access_sequencer.sv
// rtl/rggen_register_access_sequencer.sv - one-at-a-time host access sequencer for register instances
//
// Purpose: captures a host command, drives it to all register instances, waits for
// the selected register's ack (or a decode miss), and returns a registered response.
// Optional feature macro: RGGEN_ACCESS_TIMEOUT_EN (ACCESS timeout after TIMEOUT_CYCLES).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_command_*/o_command_ready     host command handshake (write flag, address, write data)
//   o_response_*/i_response_ready   host response handshake (status, read data)
//   o_register_read/write           access strobes, high only in ACCESS
//   o_register_address/write_data   captured command fields
//   i_register_select/ack/read_data per-register decode hit, completion and read data
module rggen_register_access_sequencer
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int TOTAL_REGISTERS = 1,
  parameter int TIMEOUT_CYCLES  = 15
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_command_valid,
  output logic                                  o_command_ready,
  input  logic                                  i_command_write,
  input  logic [ADDRESS_WIDTH-1:0]              i_command_address,
  input  logic [DATA_WIDTH-1:0]                 i_command_write_data,
  output logic                                  o_response_valid,
  input  logic                                  i_response_ready,
  output logic [1:0]                            o_response_status,
  output logic [DATA_WIDTH-1:0]                 o_response_read_data,
  output logic                                  o_register_read,
  output logic                                  o_register_write,
  output logic [ADDRESS_WIDTH-1:0]              o_register_address,
  output logic [DATA_WIDTH-1:0]                 o_register_write_data,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_select,
  input  logic [TOTAL_REGISTERS-1:0]            i_register_ack,
  input  logic [TOTAL_REGISTERS*DATA_WIDTH-1:0] i_register_read_data
);

  state_e                  state;
  state_e                  state_next;
  logic                    write_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0]   write_data_q;
  status_e                 status_q;
  logic [DATA_WIDTH-1:0]   read_data_q;

  logic                    hit;
  logic                    done;
  logic                    timeout;
  logic [TOTAL_REGISTERS-1:0] ack_mask;
  logic [DATA_WIDTH-1:0]   ack_data;

  assign hit      = |i_register_select;
  assign ack_mask = i_register_select & i_register_ack;
  assign done     = |ack_mask;

  rggen_or_reducer #(
    .WIDTH (DATA_WIDTH),
    .COUNT (TOTAL_REGISTERS)
  ) u_or_reducer (
    .mask   (ack_mask),
    .data   (i_register_read_data),
    .result (ack_data)
  );

`ifdef RGGEN_ACCESS_TIMEOUT_EN
  localparam int COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [COUNT_WIDTH-1:0] count;

  // Cleared while idle so every access starts from zero; counts ACCESS cycles
  // that end without an ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (state == STATE_IDLE) begin
      count <= '0;
    end else if ((state == STATE_ACCESS) && !done) begin
      count <= count + COUNT_WIDTH'(1);
    end
  end

  assign timeout = (state == STATE_ACCESS) && (count == COUNT_LAST);
`else
  // No timeout: ACCESS waits for an ack or a decode miss indefinitely.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next       = state;
    o_command_ready  = 1'b0;
    o_register_read  = 1'b0;
    o_register_write = 1'b0;
    case (state)
      STATE_IDLE: begin
        o_command_ready = 1'b1;
        if (i_command_valid) begin
          state_next = STATE_ACCESS;
        end
      end
      STATE_ACCESS: begin
        o_register_read  = !write_q;
        o_register_write = write_q;
        if (!hit || done || timeout) begin
          state_next = STATE_RESPONSE;
        end
      end
      STATE_RESPONSE: begin
        if (i_response_ready) begin
          state_next = STATE_IDLE;
        end
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= STATE_IDLE;
      write_q      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      status_q     <= STATUS_OKAY;
      read_data_q  <= '0;
    end else begin
      state <= state_next;
      if ((state == STATE_IDLE) && i_command_valid) begin
        write_q      <= i_command_write;
        address_q    <= i_command_address;
        write_data_q <= i_command_write_data;
      end
      // Response is registered on the ACCESS exit; precedence is decode miss,
      // then ack (so an ack on the final timeout cycle still wins), then timeout.
      if ((state == STATE_ACCESS) && (state_next == STATE_RESPONSE)) begin
        if (!hit) begin
          status_q    <= STATUS_DECODE_ERROR;
          read_data_q <= '0;
        end else if (done) begin
          status_q    <= STATUS_OKAY;
          read_data_q <= write_q ? '0 : ack_data;
        end else begin
          status_q    <= STATUS_TIMEOUT_ERROR;
          read_data_q <= '0;
        end
      end
    end
  end

  assign o_response_valid      = (state == STATE_RESPONSE);
  assign o_response_status     = status_q;
  assign o_response_read_data  = read_data_q;
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;

endmodule

// File: tb/tb_rggen_register_access_sequencer.sv
// tb/tb_rggen_register_access_sequencer.sv - self-checking bench for rggen_register_access_sequencer
module tb_rggen_register_access_sequencer;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TR = 4;
  localparam int TO = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_status;
  logic [DW-1:0] rsp_rdata;
  logic          reg_read;
  logic          reg_write;
  logic [AW-1:0] reg_address;
  logic [DW-1:0] reg_wdata;
  logic [TR-1:0] reg_select;
  logic [TR-1:0] reg_ack;
  logic [TR*DW-1:0] reg_rdata;

  logic [DW-1:0] reg_data [TR];
  logic          ack_on;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Bench-side address map: four registers at 0x0/0x4/0x8/0xC, and an
  // alias at 0x100 that hits registers 1 and 2 together.
  function automatic logic [TR-1:0] decode(input logic [AW-1:0] a);
    case (a)
      16'h0000: return 4'b0001;
      16'h0004: return 4'b0010;
      16'h0008: return 4'b0100;
      16'h000C: return 4'b1000;
      16'h0100: return 4'b0110;
      default:  return 4'b0000;
    endcase
  endfunction

  always_comb reg_select = decode(reg_address);
  assign reg_ack   = ack_on ? reg_select : '0;
  assign reg_rdata = {reg_data[3], reg_data[2], reg_data[1], reg_data[0]};

  rggen_register_access_sequencer #(
    .ADDRESS_WIDTH   (AW),
    .DATA_WIDTH      (DW),
    .TOTAL_REGISTERS (TR),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_command_valid      (cmd_valid),
    .o_command_ready      (cmd_ready),
    .i_command_write      (cmd_write),
    .i_command_address    (cmd_address),
    .i_command_write_data (cmd_wdata),
    .o_response_valid     (rsp_valid),
    .i_response_ready     (rsp_ready),
    .o_response_status    (rsp_status),
    .o_response_read_data (rsp_rdata),
    .o_register_read      (reg_read),
    .o_register_write     (reg_write),
    .o_register_address   (reg_address),
    .o_register_write_data(reg_wdata),
    .i_register_select    (reg_select),
    .i_register_ack       (reg_ack),
    .i_register_read_data (reg_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One complete access. ack_at = ACCESS cycle (1-based) in which the
  // selected registers start acking; hold = cycles response sits unconsumed.
  task automatic run_access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input int ack_at, input int hold);
    logic [TR-1:0] s;
    logic [1:0]    exp_st;
    logic [DW-1:0] exp_d;
    int            exp_lat;
    int            lat;
    int            strobes;
    s       = decode(addr);
    exp_st  = 2'b00;
    exp_d   = '0;
    exp_lat = ack_at + 1;
    if (s == '0) begin
      exp_st  = 2'b10;
      exp_lat = 2;
    end else begin
      if (!wr) begin
        for (int n = 0; n < TR; n++) if (s[n]) exp_d = exp_d | reg_data[n];
      end
`ifdef RGGEN_ACCESS_TIMEOUT_EN
      if (ack_at > TO) begin
        exp_st  = 2'b11;
        exp_d   = '0;
        exp_lat = TO + 1;
      end
`endif
    end

    check("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_address = addr;
    cmd_wdata   = wd;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    cmd_address = $urandom;
    cmd_wdata   = $urandom;
    lat     = 1;
    strobes = 0;
    while (!rsp_valid && lat < 100) begin
      if (lat >= ack_at) ack_on = 1'b1;
      if (reg_read || reg_write) strobes++;
      check("cmd_ready_access", cmd_ready, 1'b0);
      check("strobe_dir", {reg_read, reg_write}, wr ? 2'b01 : 2'b10);
      check("reg_address", reg_address, addr);
      check("reg_wdata", reg_wdata, wd);
      @(posedge clk); #1;
      ack_on = 1'b0;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("strobe_cycles", strobes, exp_lat - 1);
    check("rsp_status", rsp_status, exp_st);
    check("rsp_rdata", rsp_rdata, exp_d);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_status", rsp_status, exp_st);
      check("hold_rdata", rsp_rdata, exp_d);
      check("hold_cmd_ready", cmd_ready, 1'b0);
      check("hold_strobes", {reg_read, reg_write}, 2'b00);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    check("final_valid", rsp_valid, 1'b1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("after_rsp_valid", rsp_valid, 1'b0);
    check("after_rsp_cmd_ready", cmd_ready, 1'b1);
    check("after_rsp_addr_held", reg_address, addr);
  endtask

  initial begin
    logic [AW-1:0] addr_list [6];
    addr_list = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0100, 16'h2000};

    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_address = '0;
    cmd_wdata   = '0;
    rsp_ready   = 1'b0;
    ack_on      = 1'b0;
    for (int n = 0; n < TR; n++) reg_data[n] = $urandom;
    @(posedge clk); @(posedge clk); #1;

    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_status", rsp_status, 2'b00);
    check("rst_rdata", rsp_rdata, '0);
    check("rst_strobes", {reg_read, reg_write}, 2'b00);
    check("rst_address", reg_address, '0);
    check("rst_wdata", reg_wdata, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read of a single register, ack in the first ACCESS cycle.
    reg_data[0] = 32'h1234_5678;
    run_access(1'b0, 16'h0000, 32'h0, 1, 0);

    // Write to an unmapped address.
    run_access(1'b1, 16'h3000, 32'hDEAD_BEEF, 1, 0);

    // Late ack and a slow response consumer.
    run_access(1'b0, 16'h0004, 32'h0, 5, 3);

    // Two selected registers, data OR-combined.
    reg_data[1] = 32'h0000_00F0;
    reg_data[2] = 32'h0000_0F00;
    run_access(1'b0, 16'h0100, 32'h0, 1, 1);
    run_access(1'b1, 16'h0100, 32'h5555_AAAA, 2, 0);

`ifdef RGGEN_ACCESS_TIMEOUT_EN
    run_access(1'b0, 16'h0008, 32'h0, TO + 1, 0);
    run_access(1'b0, 16'h0008, 32'h0, TO, 0);
`else
    run_access(1'b0, 16'h0008, 32'h0, 20, 0);
`endif

    // Reset in the middle of an access.
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_address = 16'h0004;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_read", reg_read, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_cmd_ready", cmd_ready, 1'b1);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_strobes", {reg_read, reg_write}, 2'b00);
    check("midrst_address", reg_address, '0);
    check("midrst_status", rsp_status, 2'b00);
    @(posedge clk); #1;
    check("midrst_rsp_valid2", rsp_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_rsp_valid", rsp_valid, 1'b0);
    run_access(1'b0, 16'h000C, 32'h0, 1, 0);

    // Randomized accesses.
    for (int t = 0; t < 24; t++) begin
      logic [AW-1:0] a;
      for (int n = 0; n < TR; n++) reg_data[n] = $urandom;
      a = addr_list[$urandom_range(0, 5)];
      if (a == 16'h2000) a = 16'h2000 + AW'($urandom_range(0, 255));
      run_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 5), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rggen_register_access_sequencer.md
# rggen_register_access_sequencer

Sequences one host register access at a time onto the register-block side of a generated register map. Captures a host command, broadcasts read/write/address/data to all register instances (whose address decoders return per-register select flags), waits for the selected register's acknowledge, multiplexes read data and returns a status-qualified response. Sits between the host protocol adapter and the generated register instances.

## Interface
- ADDRESS_WIDTH, 16, register address width
- DATA_WIDTH, 32, bus data width
- TOTAL_REGISTERS, 1, number of register instances (≥1)
- TIMEOUT_CYCLES, 15, ACCESS cycles before timeout (≥1; used only with RGGEN_ACCESS_TIMEOUT_EN)

- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- i_command_valid  input  1  host command present
- o_command_ready  output  1  command accepted when valid && ready
- i_command_write  input  1  1 write, 0 read
- i_command_address  input  ADDRESS_WIDTH  target address
- i_command_write_data  input  DATA_WIDTH  write data
- o_response_valid  output  1  response present
- i_response_ready  input  1  response consumed when valid && ready
- o_response_status  output  2  00 OKAY, 10 DECODE_ERROR, 11 TIMEOUT_ERROR
- o_response_read_data  output  DATA_WIDTH  read data (0 for writes/errors)
- o_register_read  output  1  read strobe to registers
- o_register_write  output  1  write strobe to registers
- o_register_address  output  ADDRESS_WIDTH  captured address
- o_register_write_data  output  DATA_WIDTH  captured write data
- i_register_select  input  TOTAL_REGISTERS  per-register decoder hit
- i_register_ack  input  TOTAL_REGISTERS  per-register access complete
- i_register_read_data  input  TOTAL_REGISTERS*DATA_WIDTH  per-register read data, register n at [n*DATA_WIDTH +: DATA_WIDTH]

## Operation
- FSM states IDLE, ACCESS, RESPONSE.
- IDLE: o_command_ready=1. On valid&&ready capture write flag, address, write data; -> ACCESS.
- ACCESS: o_register_read = !write, o_register_write = write; hit = |i_register_select; done = |(i_register_select & i_register_ack).
  - !hit -> RESPONSE, status DECODE_ERROR, data 0 (decided in first ACCESS cycle; select is combinational from held address).
  - done -> RESPONSE, status OKAY; read data = OR over n of (select[n]&&ack[n] ? data[n] : 0); writes return 0.
  - otherwise stay in ACCESS.
- RESPONSE: o_response_valid=1, status/data held stable until i_response_ready; then -> IDLE.
- o_register_address/write_data hold captured values in all states; strobes low outside ACCESS.
- Multiple selects are legal; acks/data OR-combined.
- Reset (any state, any time): state IDLE, o_command_ready=1, o_response_valid=0, status 00, read data 0, strobes 0, address/write data 0, timeout counter 0. In-flight access discarded, no response.

## Timing
- Command accepted at edge 0 -> ACCESS during cycle 1; ack in cycle 1 -> o_response_valid in cycle 2.
- Minimum accept-to-response latency 2 cycles; minimum command spacing 3 cycles (ready low in ACCESS/RESPONSE).
- Response captured registered; no combinational path from i_register_* to o_response_*.
- i_response_ready sampled only in RESPONSE; ready asserted in the response's first cycle -> IDLE next cycle.

## Configuration
- RGGEN_ACCESS_TIMEOUT_EN defined: counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entering ACCESS, increments each ACCESS cycle without done; if TIMEOUT_CYCLES ACCESS cycles pass without done, -> RESPONSE with TIMEOUT_ERROR, data 0. done on that same final cycle wins (OKAY).
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_ERROR never produced; TIMEOUT_CYCLES ignored.

## Structure
- rggen_rtl_pkg: status typedef (OKAY, DECODE_ERROR, TIMEOUT_ERROR encodings) and state enum.
- Sub-module rggen_or_reducer: masked OR-reduction of TOTAL_REGISTERS data words.

## Test plan
- Read, select[0]=1, ack in first ACCESS cycle, data 0x1234_5678 -> response valid 2 cycles after accept, status 00, data 0x1234_5678.
- Write to unmapped address (select all 0) -> status 10, data 0, o_register_write high exactly 1 cycle.
- Ack delayed 4 cycles, i_response_ready held low 3 cycles -> response at accept+6, held stable until ready, then o_command_ready=1.
- Macro on, TIMEOUT_CYCLES=3, no ack -> status 11 after 3 ACCESS cycles; ack on 3rd cycle -> status 00.
- Two selects (data 0x00F0, 0x0F00, both ack) -> data 0x0FF0, status 00.
- rst_n low mid-ACCESS -> next cycle IDLE, no response, strobes 0, new command accepted after release.
